// File: rtl/avalon_ram_slave.sv
// Avalon-MM slave RAM with programmable wait states and a synchronous preload port.
// Define AVALON_RAM_TRACE_EN to print one line per accepted transfer and per preload word.
module avalon_ram_slave #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned PADR_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                latch_rd;
    logic                mem_we;
    logic                pre_we;
    logic                req;
    logic [ADDR_W-1:0]   idx;
    logic [PADR_W-1:0]   inst_ext;
    logic [ADDR_W-1:0]   pidx;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign req      = read | write;
    assign idx      = address[ADDR_W+1:2];
    assign inst_ext = PADR_W'(inst_addr);
    assign pidx     = inst_ext[ADDR_W+1:2];

    // Address bits outside the word index are aliased away.
    logic unused_bits;
    assign unused_bits = ^{address[31:ADDR_W+2], address[1:0], inst_ext[1:0]};

    // State, wait counter and read data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            readdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch_rd) begin
                readdata <= mem[idx];
            end
        end
    end

    // Next state: count down the wait states, bail out if the master drops its request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (!inst_input && req) begin
                    cnt_nxt = CNT_W'(WAIT_CYCLES - 1);
                    if (CNT_W'(WAIT_CYCLES - 1) == '0) begin
                        state_nxt = ACK;
                        latch_rd  = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!req) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    state_nxt = ACK;
                    latch_rd  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and memory write strobes; reset masks every write.
    always_comb begin
        waitrequest = 1'b1;
        mem_we      = 1'b0;
        pre_we      = 1'b0;
        if (reset) begin
            waitrequest = req;
        end else begin
            case (state)
                IDLE: begin
                    waitrequest = req | inst_input;
                    pre_we      = inst_input;
                end
                BUSY: begin
                    waitrequest = 1'b1;
                end
                ACK: begin
                    waitrequest = 1'b0;
                    mem_we      = write;
                end
                default: begin
                    waitrequest = 1'b1;
                end
            endcase
        end
    end

    // Memory array: preload wins over the bus, bus writes are byte-masked.
    always_ff @(posedge clk) begin
        if (pre_we) begin
            mem[pidx] <= instruction;
        end else if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteenable[b]) begin
                    mem[idx][8*b +: 8] <= writedata[8*b +: 8];
                end
            end
        end
    end

`ifdef AVALON_RAM_TRACE_EN
    always @(posedge clk) begin
        if (!reset && req && !waitrequest) begin
            $display("RAM %s addr=%h data=%h be=%b t=%0t", write ? "W" : "R", address,
                     write ? writedata : readdata, byteenable, $time);
        end
        if (pre_we) begin
            $display("RAM P addr=%h data=%h t=%0t", inst_addr, instruction, $time);
        end
    end
`else
`endif

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed self-checking bench for avalon_ram_slave (2 wait states, plus a 1-wait-state instance).
module tb_avalon_ram_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    logic [31:0] b_address;
    logic        b_write;
    logic        b_read;
    logic        b_waitrequest;
    logic [31:0] b_writedata;
    logic [3:0]  b_byteenable;
    logic [31:0] b_readdata;
    logic        b_inst_input;
    logic [7:0]  b_inst_addr;
    logic [31:0] b_instruction;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avalon_ram_slave #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .address(address), .write(write), .read(read),
        .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
        .readdata(readdata), .inst_input(inst_input), .inst_addr(inst_addr),
        .instruction(instruction)
    );

    avalon_ram_slave #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .address(b_address), .write(b_write), .read(b_read),
        .waitrequest(b_waitrequest), .writedata(b_writedata), .byteenable(b_byteenable),
        .readdata(b_readdata), .inst_input(b_inst_input), .inst_addr(b_inst_addr),
        .instruction(b_instruction)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] be, output logic [31:0] rd, output int waits);
        bit done;
        address    = addr;
        write      = wr;
        read       = !wr;
        writedata  = data;
        byteenable = be;
        waits      = 0;
        done       = 1'b0;
        rd         = '0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (waitrequest) begin
                waits++;
            end else begin
                rd   = readdata;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        write = 1'b0;
        read  = 1'b0;
        check("xfer_done", 32'(done), 32'd1);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        inst_input  = 1'b1;
        inst_addr   = a;
        instruction = d;
        @(negedge clk);
        check("preload_wait", 32'(waitrequest), 32'd1);
        @(posedge clk);
        #1;
        inst_input = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          waits;
        int          acc;
        int          high;

        reset = 1'b1;
        address = '0; write = 1'b0; read = 1'b0; writedata = '0; byteenable = '0;
        inst_input = 1'b0; inst_addr = '0; instruction = '0;
        b_address = '0; b_write = 1'b0; b_read = 1'b0; b_writedata = '0; b_byteenable = '0;
        b_inst_input = 1'b0; b_inst_addr = '0; b_instruction = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and waitrequest following the request during reset
        @(negedge clk);
        check("rst_readdata", readdata, 32'h0);
        check("rst_wait_idle", 32'(waitrequest), 32'd0);
        read = 1'b1;
        #1;
        check("rst_wait_req", 32'(waitrequest), 32'd1);
        read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        preload(8'h20, 32'h0);
        preload(8'h30, 32'h0);
        preload(8'h04, 32'h24020010);

        // Aliased read of the preloaded word
        xfer(1'b0, 32'hBFC00004, 32'h0, 4'hF, rd, waits);
        check("rd_alias_waits", 32'(waits), 32'd2);
        check("rd_alias_data", rd, 32'h24020010);

        // Byte merge
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, waits);
        check("wr_full_waits", 32'(waits), 32'd2);
        xfer(1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, waits);
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, waits);
        check("merge_data", rd, 32'hDEADBEAA);

        // Middle bytes, then an all-disabled write
        xfer(1'b1, 32'h20, 32'h11223344, 4'b0110, rd, waits);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, waits);
        check("be0110_data", rd, 32'h00223300);
        xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, waits);
        check("be0000_waits", 32'(waits), 32'd2);
        xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, waits);
        check("be0000_data", rd, 32'h00223300);

        // One wait state with read held continuously
        b_inst_input  = 1'b1;
        b_inst_addr   = 8'h00;
        b_instruction = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        b_inst_input = 1'b0;
        b_read       = 1'b1;
        acc          = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("w1_wait%0d", i), 32'(b_waitrequest), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (!b_waitrequest) begin
                acc++;
                check($sformatf("w1_data%0d", i), b_readdata, 32'hCAFEF00D);
            end
        end
        @(posedge clk);
        #1;
        b_read = 1'b0;
        check("w1_accepts", 32'(acc), 32'd3);

        // Reset pulsed while the write is in BUSY
        address = 32'h30; write = 1'b1; writedata = 32'h12345678; byteenable = 4'hF;
        @(negedge clk);
        check("rb_idle_wait", 32'(waitrequest), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rb_rst_wait", 32'(waitrequest), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rb_readdata_cleared", readdata, 32'h0);
        high = 0;
        for (int n = 0; n < 40 && waitrequest; n++) begin
            high++;
            @(negedge clk);
        end
        check("rb_restart_waits", 32'(high), 32'd2);
        @(posedge clk);
        #1;
        write = 1'b0;
        xfer(1'b0, 32'h30, 32'h0, 4'hF, rd, waits);
        check("rb_data", rd, 32'h12345678);

        // Master drops write during BUSY
        address = 32'h10; write = 1'b1; writedata = 32'h55555555; byteenable = 4'hF;
        @(posedge clk);
        #1;
        write = 1'b0;
        @(negedge clk);
        check("drop_busy_wait", 32'(waitrequest), 32'd1);
        @(negedge clk);
        check("drop_idle_wait", 32'(waitrequest), 32'd0);
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, waits);
        check("drop_rd_waits", 32'(waits), 32'd2);
        check("drop_data", rd, 32'hDEADBEAA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
